// File: rtl/multi_barrel_rotation_decoder.sv
// Recovers the rotation (direction and amount) relating an original word to a
// rotated one by testing one left-rotation candidate per clock.
module multi_barrel_rotation_decoder #(
  parameter int unsigned width = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2**width-1:0]  original,
  input  logic [2**width-1:0]  rotated,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 select,
  output logic [width-1:0]     shift
);

  localparam int unsigned n_bits = 2**width;
  localparam int unsigned half_n = n_bits / 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [width-1:0]    k_q, k_d;
  logic [n_bits-1:0]   orig_q, orig_d;
  logic [n_bits-1:0]   rot_q, rot_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                found_q, found_d;
  logic                select_q, select_d;
  logic [width-1:0]    shift_q, shift_d;

  logic [2*n_bits-1:0] dbl;
  logic [n_bits-1:0]   cand;

  // Left rotation of the captured original by the current candidate k.
  always_comb begin
    dbl  = {orig_q, orig_q} << k_q;
    cand = dbl[2*n_bits-1 -: n_bits];
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    orig_d   = orig_q;
    rot_d    = rot_q;
    found_d  = found_q;
    select_d = select_q;
    shift_d  = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          orig_d  = original;
          rot_d   = rotated;
          k_d     = '0;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (cand == rot_q) begin
          state_d = ST_DONE;
          found_d = 1'b1;
          // Report the shorter way round; a tie at N/2 stays a left rotation.
          if (32'(k_q) > half_n) begin
            select_d = 1'b1;
            shift_d  = width'(n_bits - 32'(k_q));
          end else begin
            select_d = 1'b0;
            shift_d  = k_q;
          end
        end else if (k_q == width'(n_bits - 1)) begin
          state_d  = ST_DONE;
          found_d  = 1'b0;
          select_d = 1'b0;
          shift_d  = '0;
        end else begin
          k_d = k_q + width'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SEARCH);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      orig_q   <= '0;
      rot_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      select_q <= 1'b0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      orig_q   <= orig_d;
      rot_q    <= rot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      select_q <= select_d;
      shift_q  <= shift_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign select = select_q;
  assign shift  = shift_q;

endmodule

// File: tb/tb_multi_barrel_rotation_decoder.sv
// Self-checking bench for multi_barrel_rotation_decoder (width=2, N=4):
// vector table plus hand sequences, results checked through a scoreboard queue.
module tb_multi_barrel_rotation_decoder;

  localparam int unsigned W = 2;
  localparam int unsigned N = 4;

  typedef struct {
    logic [N-1:0] o;
    logic [N-1:0] r;
    logic         f;
    logic         s;
    logic [W-1:0] sh;
    int           lat;
    bit           noise;
  } vec_t;

  typedef struct {
    logic         f;
    logic         s;
    logic [W-1:0] sh;
    int           lat;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] original;
  logic [N-1:0] rotated;
  logic         busy;
  logic         done;
  logic         found;
  logic         select;
  logic [W-1:0] shift;

  int tests = 0;
  int fails = 0;
  exp_t sb_q[$];
  vec_t vecs[12];

  multi_barrel_rotation_decoder #(.width(W)) dut (
    .clk(clk), .reset(reset), .start(start), .original(original),
    .rotated(rotated), .busy(busy), .done(done), .found(found),
    .select(select), .shift(shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Independent reference: bit i of the original lands on bit (i+k) mod N.
  function automatic exp_t model(input logic [N-1:0] o, input logic [N-1:0] r);
    exp_t e;
    e = '{1'b0, 1'b0, '0, N + 1};
    for (int k = N - 1; k >= 0; k--) begin
      bit m;
      m = 1'b1;
      for (int i = 0; i < N; i++)
        if (r[(i + k) % N] != o[i]) m = 1'b0;
      if (m) begin
        e.f   = 1'b1;
        e.s   = (k > N / 2);
        e.sh  = (k > N / 2) ? W'(N - k) : W'(k);
        e.lat = k + 2;
      end
    end
    return e;
  endfunction

  // One decode: drive start, count edges (sampling edge = 1) until done.
  task automatic run_vec(input logic [N-1:0] o, input logic [N-1:0] r,
                         input exp_t ex, input bit noise);
    exp_t e;
    int edges;
    int busy_cnt;
    bit got;
    logic         f_h;
    logic [W-1:0] sh_h;
    sb_q.push_back(ex);
    @(negedge clk);
    start = 1'b1; original = o; rotated = r;
    @(posedge clk); #1;
    edges = 1;
    busy_cnt = busy ? 1 : 0;
    got = done;
    while (!got && edges < 20) begin
      @(negedge clk);
      start    = noise && (edges < 3);
      original = N'($urandom);
      rotated  = N'($urandom);
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
      got = done;
    end
    e = sb_q.pop_front();
    check("done_seen", int'(got), 1);
    check("latency", edges, e.lat);
    check("busy_cycles", busy_cnt, e.lat - 1);
    check("found", int'(found), int'(e.f));
    check("select", int'(select), int'(e.s));
    check("shift", int'(shift), int'(e.sh));
    f_h = found; sh_h = shift;
    // A start raised during DONE must be dropped, not queued.
    @(negedge clk);
    start = noise;
    @(posedge clk); #1;
    check("done_pulse_len", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_stays", int'(busy), 0);
    check("found_hold", int'(found), int'(f_h));
    check("shift_hold", int'(shift), int'(sh_h));
  endtask

  initial begin
    vecs[0]  = '{4'b1100, 4'b1001, 1'b1, 1'b0, 2'd1, 3, 1'b0};
    vecs[1]  = '{4'b1100, 4'b0110, 1'b1, 1'b1, 2'd1, 5, 1'b0};
    vecs[2]  = '{4'b1001, 4'b0110, 1'b1, 1'b0, 2'd2, 4, 1'b0};
    vecs[3]  = '{4'b1100, 4'b1110, 1'b0, 1'b0, 2'd0, 5, 1'b0};
    vecs[4]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2, 1'b0};
    vecs[5]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 2, 1'b0};
    vecs[6]  = '{4'b0001, 4'b0010, 1'b1, 1'b0, 2'd1, 3, 1'b0};
    vecs[7]  = '{4'b0001, 4'b1000, 1'b1, 1'b1, 2'd1, 5, 1'b0};
    vecs[8]  = '{4'b0001, 4'b0100, 1'b1, 1'b0, 2'd2, 4, 1'b0};
    vecs[9]  = '{4'b0101, 4'b1010, 1'b1, 1'b0, 2'd1, 3, 1'b0};
    vecs[10] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0, 5, 1'b0};
    vecs[11] = '{4'b1010, 4'b1010, 1'b1, 1'b0, 2'd0, 2, 1'b0};

    reset = 1'b1; start = 1'b0; original = '0; rotated = '0;
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(found), 0);
    check("rst_select", int'(select), 0);
    check("rst_shift", int'(shift), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_vec(vecs[i].o, vecs[i].r, '{vecs[i].f, vecs[i].s, vecs[i].sh, vecs[i].lat},
              vecs[i].noise);

    // Restart during SEARCH (with changed inputs) and during DONE is ignored.
    run_vec(4'b1100, 4'b0110, '{1'b1, 1'b1, 2'd1, 5}, 1'b1);

    // Reset mid-search clears outputs at once and never yields a done pulse.
    @(negedge clk);
    start = 1'b1; original = 4'b1100; rotated = 4'b1110;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_found", int'(found), 0);
    check("midrst_select", int'(select), 0);
    check("midrst_shift", int'(shift), 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("midrst_no_done", int'(done), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    run_vec(4'b1001, 4'b0110, '{1'b1, 1'b0, 2'd2, 4}, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] o;
      logic [N-1:0] r;
      o = N'($urandom);
      r = (i % 2 == 0) ? N'({o, o} >> (N - (i % N))) : N'($urandom);
      run_vec(o, r, model(o, r), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
